sr_selftest_monitor: RTL and testbench

Parametrised self-test monitor for the schoolRISCV SoC. Replaces the single-register pass/fail logic with a checker that polls up to NUM_CHK architectural registers through the CPU debug read port (regAddr/regData) and compares each against its own expected value. Also runs an enable-gated timeout counter. Drives sticky pass/fail flags and per-channel match status to the top-level pins.

---
 rtl/sr_selftest_pkg.sv | 22 ++
 rtl/sr_selftest_scanner.sv | 44 ++++
 rtl/sr_selftest_monitor.sv | 115 +++++++++++
 tb/tb_sr_selftest_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_selftest_pkg.sv
// sr_selftest_pkg: shared types and constants for the schoolRISCV self-test monitor.
package sr_selftest_pkg;

  // Monitor verdict state; PASS and FAIL are terminal until reset.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // Upper bound on the number of checked registers.
  localparam int MAX_CHK = 8;

  // Width of the CPU debug register address (regAddr).
  localparam int DBG_AW = 5;

  // Width of the scan index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_selftest_scanner.sv
// sr_selftest_scanner: round-robin channel index for polling the CPU debug port.
// The index advances every cycle regardless of verdict state and wraps at
// NUM_CHK-1; dbg_addr is the address of the channel currently selected.
module sr_selftest_scanner
  import sr_selftest_pkg::*;
#(
  parameter int NUM_CHK = 2,
  parameter int IDX_W   = idx_width(NUM_CHK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DBG_AW*NUM_CHK-1:0]  chk_addr,
  output logic [IDX_W-1:0]           idx,
  output logic [DBG_AW-1:0]          dbg_addr
);

  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_q;

  // Next index: wrap after the last channel, hold at zero for a single channel.
  always_comb begin
    idx_d = idx_q;
    if (NUM_CHK == 1) begin
      idx_d = {IDX_W{1'b0}};
    end else if (idx_q == IDX_W'(NUM_CHK - 1)) begin
      idx_d = {IDX_W{1'b0}};
    end else begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= {IDX_W{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx      = idx_q;
  assign dbg_addr = chk_addr[idx_q*DBG_AW +: DBG_AW];

endmodule

// File: rtl/sr_selftest_monitor.sv
// sr_selftest_monitor: polls NUM_CHK CPU registers through the debug read port,
// keeps sticky per-channel match flags and an enable-gated timeout counter,
// and raises sticky pass/fail.
// Build option: SR_SELFTEST_ORDERED_EN makes channel k match only after all
// lower channels have matched (in-sequence checking); undefined = any order.
module sr_selftest_monitor
  import sr_selftest_pkg::*;
#(
  parameter int NUM_CHK   = 2,
  parameter int TIMEOUT_W = 8,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DBG_AW*NUM_CHK-1:0]  chk_addr,
  input  logic [DATA_W*NUM_CHK-1:0]  chk_value,
  output logic [DBG_AW-1:0]          dbg_addr,
  input  logic [DATA_W-1:0]          dbg_data,
  output logic [NUM_CHK-1:0]         match_vec,
  output logic                       pass,
  output logic                       fail,
  output logic [TIMEOUT_W-1:0]       cycles
);

  localparam int IDX_W = idx_width(NUM_CHK);
  localparam logic [TIMEOUT_W-1:0] CYC_MAX = {TIMEOUT_W{1'b1}};

  logic [IDX_W-1:0]     idx_s;
  logic [NUM_CHK-1:0]   hit_s;
  logic                 armed_s;
  state_e               state_d, state_q;
  logic [NUM_CHK-1:0]   match_d, match_q;
  logic [TIMEOUT_W-1:0] cycles_d, cycles_q;
  logic                 pass_d, pass_q;
  logic                 fail_d, fail_q;

  sr_selftest_scanner #(
    .NUM_CHK (NUM_CHK),
    .IDX_W   (IDX_W)
  ) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .chk_addr (chk_addr),
    .idx      (idx_s),
    .dbg_addr (dbg_addr)
  );

  // Compare the polled register against the selected channel's expected value.
  always_comb begin
    hit_s   = {NUM_CHK{1'b0}};
    armed_s = 1'b1;
    for (int k = 0; k < NUM_CHK; k++) begin
      hit_s[k] = armed_s && (idx_s == IDX_W'(k)) &&
                 (dbg_data == chk_value[k*DATA_W +: DATA_W]);
`ifdef SR_SELFTEST_ORDERED_EN
      armed_s = armed_s & match_q[k];
`else
      armed_s = 1'b1;
`endif
    end
  end

  // Verdict FSM next state, sticky match flags and saturating timeout count.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cycles_d = cycles_q;
    case (state_q)
      ST_RUN: begin
        match_d = match_q | hit_s;
        if (&match_d) begin
          state_d = ST_PASS;
        end else if (en && (cycles_q == CYC_MAX)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_RUN;
        end
        if (en && (cycles_q != CYC_MAX)) begin
          cycles_d = cycles_q + TIMEOUT_W'(1);
        end else begin
          cycles_d = cycles_q;
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  // Verdict, match and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      match_q  <= {NUM_CHK{1'b0}};
      cycles_q <= {TIMEOUT_W{1'b0}};
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      cycles_q <= cycles_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign match_vec = match_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_sr_selftest_monitor.sv
// tb_sr_selftest_monitor: scoreboard bench for sr_selftest_monitor with
// NUM_CHK=3, TIMEOUT_W=4. A register-file model answers the debug port.
module tb_sr_selftest_monitor;

  localparam int NUM_CHK   = 3;
  localparam int TIMEOUT_W = 4;
  localparam int DATA_W    = 32;
`ifdef SR_SELFTEST_ORDERED_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  localparam logic [4:0]  A0 = 5'd5, A1 = 5'd6, A2 = 5'd7;
  localparam logic [31:0] V0 = 32'h00213d05, V1 = 32'hdeadbeef, V2 = 32'h12345678;
  localparam logic [31:0] BAD = 32'h00000000;

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic [2:0] match;
    logic [3:0] cycles;
    logic [4:0] addr;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       en  = 1'b0;
  logic [5*NUM_CHK-1:0]       chk_addr;
  logic [DATA_W*NUM_CHK-1:0]  chk_value;
  logic [4:0]                 dbg_addr;
  logic [DATA_W-1:0]          dbg_data;
  logic [NUM_CHK-1:0]         match_vec;
  logic                       pass;
  logic                       fail;
  logic [TIMEOUT_W-1:0]       cycles;

  logic [31:0] regs [32];
  logic [4:0]  addr_t [3];
  logic [31:0] val_t  [3];

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Reference model state
  int         m_idx;
  int         m_state;   // 0 run, 1 pass, 2 fail
  logic [2:0] m_match;
  int         m_cycles;

  assign chk_addr  = {A2, A1, A0};
  assign chk_value = {V2, V1, V0};
  assign dbg_data  = regs[dbg_addr];

  always #5 clk = ~clk;

  sr_selftest_monitor #(
    .NUM_CHK   (NUM_CHK),
    .TIMEOUT_W (TIMEOUT_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .chk_addr  (chk_addr),
    .chk_value (chk_value),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .match_vec (match_vec),
    .pass      (pass),
    .fail      (fail),
    .cycles    (cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the current register file.
  task automatic model_edge(input logic e, input logic r);
    logic [2:0] nm;
    logic [2:0] low;
    if (r) begin
      m_idx = 0; m_state = 0; m_match = 3'b000; m_cycles = 0;
    end else begin
      if (m_state == 0) begin
        nm  = m_match;
        low = 3'((1 << m_idx) - 1);
        if (regs[addr_t[m_idx]] == val_t[m_idx] && (!ORD || ((m_match & low) == low)))
          nm[m_idx] = 1'b1;
        if (nm == 3'b111) m_state = 1;
        else if (e && m_cycles == 15) m_state = 2;
        if (e && m_cycles < 15) m_cycles++;
        m_match = nm;
      end
      m_idx = (m_idx + 1) % 3;
    end
  endtask

  // Drive one cycle: predict, push, clock, pop and compare.
  task automatic step(input logic e, input logic r);
    exp_t x;
    en  = e;
    rst = r;
    model_edge(e, r);
    x.pass   = (m_state == 1);
    x.fail   = (m_state == 2);
    x.match  = m_match;
    x.cycles = 4'(m_cycles);
    x.addr   = addr_t[m_idx];
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("pass",      {31'd0, pass},   {31'd0, x.pass});
    check_eq("fail",      {31'd0, fail},   {31'd0, x.fail});
    check_eq("match_vec", {29'd0, match_vec}, {29'd0, x.match});
    check_eq("cycles",    {28'd0, cycles}, {28'd0, x.cycles});
    check_eq("dbg_addr",  {27'd0, dbg_addr}, {27'd0, x.addr});
  endtask

  initial begin
    bit seen;
    addr_t = '{A0, A1, A2};
    val_t  = '{V0, V1, V2};
    for (int i = 0; i < 32; i++) regs[i] = BAD;

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("rst_pass", {31'd0, pass}, 32'd0);
    check_eq("rst_fail", {31'd0, fail}, 32'd0);
    check_eq("rst_match", {29'd0, match_vec}, 32'd0);
    check_eq("rst_cycles", {28'd0, cycles}, 32'd0);
    check_eq("rst_addr", {27'd0, dbg_addr}, 32'd5);

    // Never matching: fail on the 16th enabled edge
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    check_eq("to_fail_15", {31'd0, fail}, 32'd0);
    check_eq("to_cyc_15", {28'd0, cycles}, 32'd15);
    step(1'b1, 1'b0);
    check_eq("to_fail_16", {31'd0, fail}, 32'd1);
    check_eq("to_pass_16", {31'd0, pass}, 32'd0);
    check_eq("to_match_16", {29'd0, match_vec}, 32'd0);

    // en toggling: fail after 32 cycles, late matches ignored
    step(1'b0, 1'b1);
    for (int i = 0; i < 31; i++) step(logic'(i % 2), 1'b0);
    check_eq("tog_fail_31", {31'd0, fail}, 32'd0);
    step(1'b1, 1'b0);
    check_eq("tog_fail_32", {31'd0, fail}, 32'd1);
    regs[A0] = V0; regs[A1] = V1; regs[A2] = V2;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    check_eq("tog_late_pass", {31'd0, pass}, 32'd0);
    check_eq("tog_late_match", {29'd0, match_vec}, 32'd0);

    // Staggered matches: reg7 from reset, reg5 at 10, reg6 at 30
    regs[A0] = BAD; regs[A1] = BAD; regs[A2] = V2;
    step(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (i == 10) regs[A0] = V0;
      step(logic'(i % 3 == 0), 1'b0);
      if (i == 9)  check_eq("stag_m9",  {29'd0, match_vec}, ORD ? 32'd0 : 32'd4);
      if (i == 29) check_eq("stag_m29", {29'd0, match_vec}, ORD ? 32'd1 : 32'd5);
    end
    regs[A1] = V1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(logic'(i % 3 == 0), 1'b0);
      if (pass) seen = 1'b1;
    end
    check_eq("stag_pass_3", {31'd0, seen}, 32'd1);
    check_eq("stag_fail", {31'd0, fail}, 32'd0);

    // Final match on the timeout edge: pass wins; then a reset pulse
    regs[A0] = V0; regs[A1] = V1; regs[A2] = BAD;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    check_eq("tie_cyc", {28'd0, cycles}, 32'd15);
    check_eq("tie_match", {29'd0, match_vec}, 32'd3);
    check_eq("tie_fail_pre", {31'd0, fail}, 32'd0);
    regs[A2] = V2;
    step(1'b1, 1'b0);
    check_eq("tie_pass", {31'd0, pass}, 32'd1);
    check_eq("tie_fail", {31'd0, fail}, 32'd0);
    step(1'b1, 1'b1);
    check_eq("rp_pass", {31'd0, pass}, 32'd0);
    check_eq("rp_match", {29'd0, match_vec}, 32'd0);
    check_eq("rp_cycles", {28'd0, cycles}, 32'd0);
    check_eq("rp_addr", {27'd0, dbg_addr}, 32'd5);
    regs[A0] = BAD; regs[A1] = BAD; regs[A2] = BAD;
    step(1'b1, 1'b0);
    check_eq("rp_addr_next", {27'd0, dbg_addr}, 32'd6);

    // Out-of-order arrival: channel 1 before channel 0
    step(1'b0, 1'b1);
    regs[A1] = V1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check_eq("ord_m_ch1", {29'd0, match_vec}, ORD ? 32'd0 : 32'd2);
    regs[A0] = V0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check_eq("ord_m_ch01", {29'd0, match_vec}, 32'd3);
    regs[A2] = V2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check_eq("ord_pass", {31'd0, pass}, 32'd1);
    check_eq("ord_cycles", {28'd0, cycles}, 32'd0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
